// File: rtl/frame_unloader.sv
// Frame unloader: captures each completed latch frame into a DEPTH-frame FIFO
// and drains it word by word over a valid/ready stream with end-of-frame marking.
module frame_unloader #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          frame_in [0:STAGE-1],
  input  logic                       frame_rdy,
  input  logic                       clr_ovf,
  output logic [DWIDTH-1:0]          out_data,
  output logic [$clog2(STAGE)-1:0]   out_idx,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(STAGE);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic                rdy_q;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                ovf_q, ovf_d;
  logic [DWIDTH-1:0]   fifo_q [DEPTH][STAGE];

  logic cap;
  logic wr_en;

  // Rising edge of the latch's frame-ready level; full is judged before any same-cycle pop.
  assign cap   = frame_rdy & ~rdy_q;
  assign wr_en = cap & ~full;

  // The extra wrap bit makes the pointer difference the true occupancy.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overflow  = ovf_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    idx_d      = idx_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
    out_data_d = '0;
    out_last_d = 1'b0;
    ovf_d      = ovf_q;

    if (cap && full)  ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    case (state_q)
      IDLE: if (!empty) state_d = SEND;
      SEND: begin
        if (out_ready) begin
          if (idx_q == IW'(STAGE-1)) begin
            idx_d    = '0;
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            if (wr_ptr_d == rd_ptr_d) state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == SEND) begin
      // A frame written on this same edge into the slot about to be read is forwarded.
      if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
        out_data_d = frame_in[idx_d];
      else
        out_data_d = fifo_q[rd_ptr_d[AW-1:0]][idx_d];
      out_last_d = (idx_d == IW'(STAGE-1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      ovf_q      <= 1'b0;
      // NOTE: the frame store is reset too, so no stale word can ever reach out_data.
      for (int f = 0; f < DEPTH; f++)
        for (int w = 0; w < STAGE; w++)
          fifo_q[f][w] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rdy_q      <= frame_rdy;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      ovf_q      <= ovf_d;
      if (wr_en)
        for (int w = 0; w < STAGE; w++)
          fifo_q[wr_ptr_q[AW-1:0]][w] <= frame_in[w];
    end
  end

endmodule

// File: tb/tb_frame_unloader.sv
// Self-checking bench for frame_unloader: a scoreboard queue of expected words,
// filled when frames are driven and emptied as the DUT hands words downstream.
module tb_frame_unloader;

  localparam int STAGE  = 8;
  localparam int DWIDTH = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DWIDTH-1:0] frame_in [0:STAGE-1];
  logic              frame_rdy;
  logic              clr_ovf;
  logic [DWIDTH-1:0] out_data;
  logic [2:0]        out_idx;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [2:0]        level;
  logic              full;
  logic              empty;
  logic              overflow;

  word_t sb [$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    valid_cycles = 0;

  frame_unloader #(.STAGE(STAGE), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_in  (frame_in),
    .frame_rdy (frame_rdy),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfers complete on the next rising edge; sample them at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cycles++;
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          word_t e;
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_idx",  32'(out_idx),  32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // Drives one frame and a single-cycle frame_rdy pulse; returns 1ns after the capture edge.
  task automatic send_frame(input logic [7:0] base, input bit accept);
    @(posedge clk); #1;
    for (int i = 0; i < STAGE; i++) frame_in[i] = base + 8'(i);
    frame_rdy = 1'b1;
    if (accept)
      for (int i = 0; i < STAGE; i++) sb.push_back('{base + 8'(i), 3'(i), i == STAGE-1});
    @(posedge clk); #1;
    frame_rdy = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (!out_valid && empty && sb.size() == 0) done = 1'b1;
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; frame_rdy = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < STAGE; i++) frame_in[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data),  0);
    check("rst_idx",   32'(out_idx),   0);
    check("rst_last",  32'(out_last),  0);
    check("rst_level", 32'(level),     0);
    check("rst_full",  32'(full),      0);
    check("rst_empty", 32'(empty),     1);
    check("rst_ovf",   32'(overflow),  0);

    // 1: single frame, ready held high
    out_ready = 1'b1;
    send_frame(8'h10, 1'b1);
    valid_cycles = 0;
    check("t1_valid_at_cap", 32'(out_valid), 0);
    check("t1_level_at_cap", 32'(level), 1);
    @(posedge clk); #1;
    check("t1_valid_lat", 32'(out_valid), 1);
    check("t1_first_data", 32'(out_data), 32'h10);
    wait_drain("t1");
    check("t1_valid_cycles", 32'(valid_cycles), 8);

    // 2: ready toggling, starting low on the first valid cycle
    out_ready = 1'b0;
    send_frame(8'h10, 1'b1);
    valid_cycles = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && !(!out_valid && empty); c++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    check("t2_valid_cycles", 32'(valid_cycles), 16);
    check("t2_sb_left", 32'(sb.size()), 0);

    // 3: fill to full, overflow, clear, drain
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      send_frame(8'hA0 + 8'(f * 16), 1'b1);
      check("t3_level", 32'(level), 32'(f + 1));
    end
    check("t3_full", 32'(full), 1);
    check("t3_ovf_before", 32'(overflow), 0);
    send_frame(8'hE0, 1'b0);
    check("t3_ovf_set", 32'(overflow), 1);
    check("t3_level_after_drop", 32'(level), 4);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 0);
    out_ready = 1'b1;
    wait_drain("t3");
    check("t3_empty", 32'(empty), 1);

    // 4: capture on the edge that pops word 7 of the only stored frame
    send_frame(8'h40, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("t4_idx7", 32'(out_idx), 7);
    for (int i = 0; i < STAGE; i++) frame_in[i] = 8'h50 + 8'(i);
    frame_rdy = 1'b1;
    for (int i = 0; i < STAGE; i++) sb.push_back('{8'h50 + 8'(i), 3'(i), i == STAGE-1});
    @(posedge clk); #1;
    frame_rdy = 1'b0;
    check("t4_level", 32'(level), 1);
    check("t4_valid", 32'(out_valid), 1);
    check("t4_idx0", 32'(out_idx), 0);
    check("t4_data0", 32'(out_data), 32'h50);
    wait_drain("t4");

    // 5a: frame_rdy held high for 6 cycles gives one capture
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < STAGE; i++) frame_in[i] = 8'h60 + 8'(i);
    frame_rdy = 1'b1;
    for (int i = 0; i < STAGE; i++) sb.push_back('{8'h60 + 8'(i), 3'(i), i == STAGE-1});
    repeat (6) @(posedge clk);
    #1 frame_rdy = 1'b0;
    @(posedge clk); #1;
    check("t5_level_held", 32'(level), 1);
    out_ready = 1'b1;
    wait_drain("t5");

    // 5b: frame_rdy high through reset release gives no capture
    frame_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_level_rstrel", 32'(level), 0);
    check("t5_valid_rstrel", 32'(out_valid), 0);
    frame_rdy = 1'b0;

    // 6: reset while word 3 of two queued frames is presented
    out_ready = 1'b0;
    send_frame(8'h70, 1'b1);
    send_frame(8'h80, 1'b1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 3) seen = 1'b1;
    end
    check("t6_reached_w3", 32'(seen), 1);
    check("t6_w3_data", 32'(out_data), 32'h73);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_empty", 32'(empty), 1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    send_frame(8'h90, 1'b1);
    wait_drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
